eco32_core_ifu_evm_gen: RTL and testbench
=========================================

Name: eco32_core_ifu_evm_gen

Overview:
Event-message generator that produces the {erx, eid} entries written into the IFU event FIFO. It latches per-source event requests and selects one pending source per cycle by round-robin. It then writes the entry into the FIFO, throttled by the FIFO's almost-full flag. It also tracks per-source overflow (a request that arrives while the source is already pending).

Parameters:
NSRC, 8, number of event sources (1..16); source index i is emitted as eid = i
ERX_W, 5, width of the event register-index field
EID_W, 4, width of the event id field; must satisfy 2^EID_W >= NSRC

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset asserted)
ev_req  in  NSRC  per-source event request pulse; one bit per source, 1-cycle pulse per event
ev_erx  in  NSRC*ERX_W  per-source erx payload; slice i is valid while ev_req[i]=1
ev_msk  in  NSRC  1 = source i is held (pending kept, never granted)
ovf_clr  in  1  pulse; clears all ev_ovf bits
o_stb  out  1  FIFO write strobe; 1-cycle pulse per entry
o_erx  out  ERX_W  entry erx field
o_eid  out  EID_W  entry eid field (source index)
o_af  in  1  FIFO almost-full; 1 = do not issue new writes
ev_pend  out  NSRC  per-source pending flags
ev_ovf  out  NSRC  sticky per-source overflow flags
busy  out  1  OR of ev_pend, plus o_stb

Behaviour:
- Reset (rst=0, asynchronous): o_stb=0, o_erx=0, o_eid=0, ev_pend=0, ev_ovf=0, busy=0. The stored erx registers are cleared to 0. The RR pointer is set to NSRC-1, so source 0 has first priority. Reset takes effect immediately, mid-burst included; no partial entry is emitted after reset is released.
- Pending capture:
  - If ev_req[i]=1 and pend[i]=0: next cycle pend[i]=1 and erx_q[i] = ev_erx slice i.
  - If ev_req[i]=1 and pend[i]=1 and source i is not granted this cycle: overflow. ev_ovf[i] is set, erx_q[i] is unchanged (first event wins), and the new event is dropped.
  - If ev_req[i]=1 in the same cycle source i is granted: no overflow. pend[i] stays 1 and erx_q[i] loads the new value.
- Grant:
  - Eligible set = pend & ~ev_msk.
  - A grant is issued in a cycle when the eligible set is non-zero and o_af=0, both sampled in the same cycle.
  - Winner = first eligible index searching upward from ptr+1 modulo NSRC.
  - On grant: pend[winner] is cleared (unless re-requested, see above) and ptr <= winner.
  - At most one grant per cycle.
- Output register:
  - On grant, next cycle: o_stb=1, o_erx=erx_q[winner], o_eid=winner. Otherwise o_stb=0.
  - o_erx and o_eid hold their last value when o_stb=0.
- Latency: ev_req at cycle t -> pend at t+1 -> o_stb at t+2 (af=0, no competition).
- Backpressure:
  - o_af is sampled at grant time. Because o_stb is registered, at most one write lands after o_af rises.
  - The FIFO's almost-full slack (>=2 free entries when af asserts) absorbs this write; no other flow control exists.
  - While o_af=1, pend bits are retained. Issue resumes on the first cycle with o_af=0.
- Mask: a masked source keeps pend and may overflow. When its mask bit clears, it competes normally.
- ev_ovf:
  - Sticky.
  - ovf_clr=1 clears all bits, except a bit whose overflow event occurs in the same cycle: set wins.
- busy = |ev_pend | o_stb.
- Width rules: eid = zero-extended source index truncated to EID_W. No arithmetic beyond the modulo-NSRC pointer search.

Test Plan:
1. Hold rst=0 for 3 cycles with random ev_req -> o_stb=0, ev_pend=0, ev_ovf=0, busy=0. Release rst; no o_stb until a request.
2. ev_req[3]=1 with erx slice 3 = 5'h11 at cycle t, o_af=0 -> o_stb=1 at t+2 only, o_erx=5'h11, o_eid=4'd3. ev_pend[3] is 1 at t+1 and 0 at t+2.
3. ev_req[0], [2], [5] pulsed in the same cycle -> three consecutive o_stb with eid 0, 2, 5. Then pulse ev_req[0] and [5] together -> order is 0, 5 (pointer wraps after 5).
4. o_af=1 held 10 cycles with sources 1 and 4 pending -> no o_stb, ev_pend=0x12 retained. Drop o_af -> eid 1 then eid 4 on consecutive cycles. Raise o_af one cycle after a grant -> exactly one extra o_stb.
5. With o_af=1, pulse ev_req[1] with erx 5'h03, then with erx 5'h1F -> ev_ovf[1]=1. After release, the emitted erx is 5'h03. Pulse ovf_clr -> ev_ovf=0. ovf_clr in the same cycle as a new overflow -> bit stays 1.
6. Set ev_msk[2]=1 with source 2 pending -> never granted and stays pending. Clear the mask -> emitted. Assert rst=0 mid-burst of 4 pendings -> outputs 0 in the same cycle, and nothing is emitted after release.

Source files
------------

// File: rtl/eco32_core_ifu_evm_gen_if.sv
// FIFO write-side bundle of the IFU event-message generator.
// The generator drives the entry strobe and fields, and the FIFO returns almost-full.
interface eco32_core_ifu_evm_gen_if #(
  parameter int ERX_W = 5,
  parameter int EID_W = 4
);
  logic             o_stb;
  logic [ERX_W-1:0] o_erx;
  logic [EID_W-1:0] o_eid;
  logic             o_af;

  modport master (output o_stb, output o_erx, output o_eid, input o_af);
  modport slave  (input o_stb, input o_erx, input o_eid, output o_af);
endinterface

// File: rtl/eco32_core_ifu_evm_gen.sv
// IFU event-message generator: latches per-source events, picks one by round-robin,
// and writes {erx, eid} into the event FIFO while respecting its almost-full flag.
module eco32_core_ifu_evm_gen #(
  parameter int NSRC  = 8,
  parameter int ERX_W = 5,
  parameter int EID_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NSRC-1:0]         ev_req,
  input  logic [NSRC*ERX_W-1:0]   ev_erx,
  input  logic [NSRC-1:0]         ev_msk,
  input  logic                    ovf_clr,
  eco32_core_ifu_evm_gen_if.master fifo,
  output logic [NSRC-1:0]         ev_pend,
  output logic [NSRC-1:0]         ev_ovf,
  output logic                    busy
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]  pend_q, pend_d;
  logic [NSRC-1:0]  ovf_q, ovf_d, ovf_set;
  logic [ERX_W-1:0] erx_q [NSRC];
  logic [ERX_W-1:0] erx_d [NSRC];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             stb_q, stb_d;
  logic [ERX_W-1:0] oerx_q, oerx_d;
  logic [EID_W-1:0] oeid_q, oeid_d;

  logic [NSRC-1:0]  elig;
  logic [PTR_W-1:0] win;
  logic             found;
  logic             grant;

  assign elig  = pend_q & ~ev_msk;
  assign grant = found & ~fifo.o_af;

  // Round-robin search starts just past the last winner and wraps modulo NSRC.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NSRC; k++) begin
      int               idx;
      logic [PTR_W-1:0] cand;
      idx  = (int'(ptr_q) + k) % NSRC;
      cand = PTR_W'(idx);
      if (!found && elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A request landing on the source being granted this cycle re-arms it instead of overflowing.
  always_comb begin
    pend_d  = pend_q;
    erx_d   = erx_q;
    ovf_set = '0;
    for (int i = 0; i < NSRC; i++) begin
      logic gnt_i;
      gnt_i = grant && (win == PTR_W'(i));
      if (ev_req[i]) begin
        if (!pend_q[i] || gnt_i) begin
          pend_d[i] = 1'b1;
          erx_d[i]  = ev_erx[i*ERX_W +: ERX_W];
        end else begin
          ovf_set[i] = 1'b1;
        end
      end else if (gnt_i) begin
        pend_d[i] = 1'b0;
      end
    end
    ovf_d  = (ovf_clr ? '0 : ovf_q) | ovf_set;
    ptr_d  = grant ? win : ptr_q;
    stb_d  = grant;
    oerx_d = grant ? erx_q[win] : oerx_q;
    oeid_d = grant ? EID_W'(win) : oeid_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      ovf_q  <= '0;
      for (int i = 0; i < NSRC; i++) erx_q[i] <= '0;
      ptr_q  <= PTR_W'(NSRC - 1);
      stb_q  <= 1'b0;
      oerx_q <= '0;
      oeid_q <= '0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      erx_q  <= erx_d;
      ptr_q  <= ptr_d;
      stb_q  <= stb_d;
      oerx_q <= oerx_d;
      oeid_q <= oeid_d;
    end
  end

  assign fifo.o_stb = stb_q;
  assign fifo.o_erx = oerx_q;
  assign fifo.o_eid = oeid_q;
  assign ev_pend    = pend_q;
  assign ev_ovf     = ovf_q;
  assign busy       = (|pend_q) | stb_q;

endmodule

// File: tb/tb_eco32_core_ifu_evm_gen.sv
// Bench for eco32_core_ifu_evm_gen: a behavioural model steps alongside the DUT and is
// compared every cycle, with directed scenarios carrying literal expectations.
module tb_eco32_core_ifu_evm_gen;
  localparam int NSRC  = 8;
  localparam int ERX_W = 5;
  localparam int EID_W = 4;
  localparam int EW    = NSRC * ERX_W;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NSRC-1:0] evReq = '0;
  logic [EW-1:0]   evErx = '0;
  logic [NSRC-1:0] evMsk = '0;
  logic            ovfClr = 1'b0;
  logic            af = 1'b0;
  logic [NSRC-1:0] evPend;
  logic [NSRC-1:0] evOvf;
  logic            busy;

  int checks = 0;
  int errors = 0;
  bit checking = 1'b0;

  bit mPend [NSRC];
  bit mOvf  [NSRC];
  int mErx  [NSRC];
  int mPtr  = NSRC - 1;
  bit mStb  = 1'b0;
  int mOErx = 0;
  int mOEid = 0;

  eco32_core_ifu_evm_gen_if #(.ERX_W(ERX_W), .EID_W(EID_W)) fifoIf ();
  assign fifoIf.o_af = af;

  eco32_core_ifu_evm_gen #(.NSRC(NSRC), .ERX_W(ERX_W), .EID_W(EID_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .ev_req  (evReq),
    .ev_erx  (evErx),
    .ev_msk  (evMsk),
    .ovf_clr (ovfClr),
    .fifo    (fifoIf.master),
    .ev_pend (evPend),
    .ev_ovf  (evOvf),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < NSRC; i++) begin
      mPend[i] = 1'b0;
      mOvf[i]  = 1'b0;
      mErx[i]  = 0;
    end
    mPtr  = NSRC - 1;
    mStb  = 1'b0;
    mOErx = 0;
    mOEid = 0;
  endtask

  // One clock of the event generator described as: pick, emit, then absorb new requests.
  task automatic modelStep();
    int w;
    w = -1;
    if (!af) begin
      for (int k = 1; k <= NSRC; k++) begin
        int j;
        j = (mPtr + k) % NSRC;
        if (w < 0 && mPend[j] && !evMsk[j]) w = j;
      end
    end
    if (w >= 0) begin
      mStb  = 1'b1;
      mOErx = mErx[w];
      mOEid = w % (1 << EID_W);
      mPtr  = w;
    end else begin
      mStb = 1'b0;
    end
    if (ovfClr) for (int i = 0; i < NSRC; i++) mOvf[i] = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (evReq[i]) begin
        if (!mPend[i] || i == w) begin
          mPend[i] = 1'b1;
          mErx[i]  = int'(evErx[i*ERX_W +: ERX_W]);
        end else begin
          mOvf[i] = 1'b1;
        end
      end else if (i == w) begin
        mPend[i] = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) modelReset();
    else      modelStep();
  end

  always @(negedge clk) begin
    #2;
    if (checking) begin
      logic [NSRC-1:0] ePend, eOvf;
      bit anyPend;
      anyPend = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        ePend[i] = mPend[i];
        eOvf[i]  = mOvf[i];
        anyPend  = anyPend | mPend[i];
      end
      checkOutput("model_stb",  fifoIf.o_stb, mStb);
      checkOutput("model_erx",  fifoIf.o_erx, mOErx);
      checkOutput("model_eid",  fifoIf.o_eid, mOEid);
      checkOutput("model_pend", evPend, ePend);
      checkOutput("model_ovf",  evOvf, eOvf);
      checkOutput("model_busy", busy, anyPend | mStb);
    end
  end

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  function automatic logic [EW-1:0] erxAt(input int i, input logic [ERX_W-1:0] v);
    logic [EW-1:0] r;
    r = '0;
    r[i*ERX_W +: ERX_W] = v;
    return r;
  endfunction

  task automatic applyStimulus(input logic [NSRC-1:0] req, input logic [EW-1:0] erx);
    evReq = req;
    evErx = erx;
    tick();
    evReq = '0;
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #3;
    rst = 1'b0;
    #1;
    checking = 1'b1;

    // Reset held with random request traffic
    for (int c = 0; c < 3; c++) begin
      evReq = NSRC'($urandom);
      evErx = EW'({$urandom, $urandom});
      tick();
      checkOutput("rst_stb", fifoIf.o_stb, 0);
      checkOutput("rst_pend", evPend, 0);
      checkOutput("rst_ovf", evOvf, 0);
      checkOutput("rst_busy", busy, 0);
    end
    evReq = '0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("idle_stb", fifoIf.o_stb, 0);
    end

    // Single event latency
    applyStimulus(8'h08, erxAt(3, 5'h11));
    checkOutput("lat_pend_t1", evPend[3], 1);
    checkOutput("lat_stb_t1", fifoIf.o_stb, 0);
    tick();
    checkOutput("lat_stb_t2", fifoIf.o_stb, 1);
    checkOutput("lat_erx", fifoIf.o_erx, 5'h11);
    checkOutput("lat_eid", fifoIf.o_eid, 3);
    checkOutput("lat_pend_t2", evPend[3], 0);
    tick();
    checkOutput("lat_stb_t3", fifoIf.o_stb, 0);

    // Round-robin ordering from a fresh pointer, then wrap
    pulseReset();
    applyStimulus(8'h25, erxAt(0, 5'h01) | erxAt(2, 5'h02) | erxAt(5, 5'h05));
    checkOutput("rr_pend", evPend, 8'h25);
    tick(); checkOutput("rr_eid0", fifoIf.o_eid, 0);
    tick(); checkOutput("rr_eid2", fifoIf.o_eid, 2);
    tick(); checkOutput("rr_eid5", fifoIf.o_eid, 5);
            checkOutput("rr_erx5", fifoIf.o_erx, 5'h05);
    applyStimulus(8'h21, erxAt(0, 5'h0A) | erxAt(5, 5'h0B));
    tick(); checkOutput("wrap_eid0", fifoIf.o_eid, 0);
    tick(); checkOutput("wrap_eid5", fifoIf.o_eid, 5);

    // Almost-full holds pendings; one in-flight write lands after af rises
    af = 1'b1;
    applyStimulus(8'h12, erxAt(1, 5'h07) | erxAt(4, 5'h09));
    for (int c = 0; c < 10; c++) begin
      checkOutput("af_stb", fifoIf.o_stb, 0);
      checkOutput("af_pend", evPend, 8'h12);
      tick();
    end
    af = 1'b0;
    tick(); checkOutput("af_rel_eid1", fifoIf.o_eid, 1); checkOutput("af_rel_stb1", fifoIf.o_stb, 1);
    tick(); checkOutput("af_rel_eid4", fifoIf.o_eid, 4); checkOutput("af_rel_stb4", fifoIf.o_stb, 1);
    applyStimulus(8'h12, erxAt(1, 5'h0C) | erxAt(4, 5'h0D));
    tick();
    af = 1'b1;
    checkOutput("af_late_stb", fifoIf.o_stb, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("af_late_hold", fifoIf.o_stb, 0);
      checkOutput("af_late_pend", evPend, 8'h10);
    end
    af = 1'b0;
    tick(); checkOutput("af_late_eid4", fifoIf.o_eid, 4);
    tick();

    // Overflow keeps the first payload; clear, and set beats clear
    af = 1'b1;
    applyStimulus(8'h02, erxAt(1, 5'h03));
    applyStimulus(8'h02, erxAt(1, 5'h1F));
    checkOutput("ovf_set", evOvf, 8'h02);
    af = 1'b0;
    tick();
    checkOutput("ovf_first_erx", fifoIf.o_erx, 5'h03);
    checkOutput("ovf_first_eid", fifoIf.o_eid, 1);
    ovfClr = 1'b1;
    tick();
    ovfClr = 1'b0;
    checkOutput("ovf_clr", evOvf, 0);
    af = 1'b1;
    applyStimulus(8'h02, erxAt(1, 5'h0A));
    evReq = 8'h02;
    ovfClr = 1'b1;
    tick();
    evReq = '0;
    ovfClr = 1'b0;
    checkOutput("ovf_set_wins", evOvf, 8'h02);
    af = 1'b0;
    tick();
    tick();

    // Masked source stays pending until unmasked
    evMsk = 8'h04;
    applyStimulus(8'h04, erxAt(2, 5'h15));
    for (int c = 0; c < 6; c++) begin
      checkOutput("msk_stb", fifoIf.o_stb, 0);
      checkOutput("msk_pend", evPend, 8'h04);
      tick();
    end
    evMsk = '0;
    tick();
    checkOutput("msk_rel_eid", fifoIf.o_eid, 2);
    checkOutput("msk_rel_erx", fifoIf.o_erx, 5'h15);
    tick();

    // Asynchronous reset in the middle of a burst
    applyStimulus(8'h0F, erxAt(0, 5'h11) | erxAt(1, 5'h12) | erxAt(2, 5'h13) | erxAt(3, 5'h14));
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_stb", fifoIf.o_stb, 0);
    checkOutput("mid_rst_pend", evPend, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_erx", fifoIf.o_erx, 0);
    checkOutput("mid_rst_eid", fifoIf.o_eid, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      checkOutput("post_rst_stb", fifoIf.o_stb, 0);
      checkOutput("post_rst_pend", evPend, 0);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      evReq  = NSRC'($urandom & $urandom);
      evErx  = EW'({$urandom, $urandom});
      if ($urandom_range(0, 31) == 0) evMsk = NSRC'($urandom & $urandom);
      af     = ($urandom_range(0, 3) == 0);
      ovfClr = ($urandom_range(0, 15) == 0);
      rst    = ($urandom_range(0, 299) != 0);
      tick();
    end
    evReq = '0;
    ovfClr = 1'b0;
    rst = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
